// File: rtl/three_input_gate_pkg.sv
// -----------------------------------------------------------------------------
// three_input_gate_pkg
// Purpose : shared definitions for the selectable three-input gate cell.
//           Holds the opcode encoding used by the decode and the reset value
//           of the registered output.
// Contents:
//   op_e        2-bit opcode: AND / OR / XOR / NAND
//   OUT_RST_VAL per-lane value of o_f while reset is asserted
// -----------------------------------------------------------------------------
package three_input_gate_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   localparam logic OUT_RST_VAL = 1'b0;

endpackage : three_input_gate_pkg

// File: rtl/three_input_logic.sv
// -----------------------------------------------------------------------------
// three_input_logic
// Purpose : purely combinational per-lane gate function. Every lane of the
//           operands is combined independently according to the opcode.
// Parameters:
//   WIDTH    lane count
// Ports:
//   a_i      in  WIDTH  operand A
//   b_i      in  WIDTH  operand B
//   c_i      in  WIDTH  operand C
//   code_i   in  2      opcode (see three_input_gate_pkg::op_e)
//   f_o      out WIDTH  gate result, combinational
// -----------------------------------------------------------------------------
module three_input_logic
   import three_input_gate_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  logic [1:0]       code_i,
   output logic [WIDTH-1:0] f_o
);

   // The default assignment up front plus the default branch mean an unknown
   // opcode resolves to all-zero rather than holding or propagating a value.
   always_comb begin
      f_o = '0;
      case (code_i)
         OP_AND:  f_o = a_i & b_i & c_i;
         OP_OR:   f_o = a_i | b_i | c_i;
         OP_XOR:  f_o = a_i ^ b_i ^ c_i;
         OP_NAND: f_o = ~(a_i & b_i & c_i);
         default: f_o = '0;
      endcase
   end

endmodule : three_input_logic

// File: rtl/three_input_gate.sv
// -----------------------------------------------------------------------------
// three_input_gate
// Purpose : selectable three-input logic cell (AND / OR / XOR / NAND) with a
//           registered result, applied bitwise per lane.
// Parameters:
//   WIDTH    lane count of a, b, c and o_f (default 1)
// Ports:
//   i_clk    in  1      clock, rising edge
//   i_rst_n  in  1      asynchronous active-low reset
//   a        in  WIDTH  operand A
//   b        in  WIDTH  operand B
//   c        in  WIDTH  operand C
//   i_code   in  2      operation select (00 AND, 01 OR, 10 XOR, 11 NAND)
//   o_f      out WIDTH  registered gate result
// Configuration:
//   THREE_INPUT_GATE_IN_REG_EN  when defined, operands and opcode are
//                               registered before the decode (reset value 0),
//                               giving 2 cycles of latency instead of 1.
// Interface: no valid/ready handshake. Inputs are sampled on every rising
//   edge and a new result is presented every cycle; there is no back-pressure.
// -----------------------------------------------------------------------------
module three_input_gate
   import three_input_gate_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       i_code,
   output logic [WIDTH-1:0] o_f
);

   // Operands as seen by the decode (either direct or through the input stage)
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH-1:0] c_s;
   logic [1:0]       code_s;

`ifdef THREE_INPUT_GATE_IN_REG_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic [1:0]       code_q;

   // Opcode and operands are captured together so a simultaneous change of
   // both is always decoded as a consistent pair. Reset opcode 00 (AND) with
   // zero operands decodes to 0, so o_f stays 0 for the first two edges.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         code_q <= 2'b00;
      end else begin
         a_q    <= a;
         b_q    <= b;
         c_q    <= c;
         code_q <= i_code;
      end
   end

   assign a_s    = a_q;
   assign b_s    = b_q;
   assign c_s    = c_q;
   assign code_s = code_q;
`else
   assign a_s    = a;
   assign b_s    = b;
   assign c_s    = c;
   assign code_s = i_code;
`endif

   logic [WIDTH-1:0] f_d;
   logic [WIDTH-1:0] f_q;

   three_input_logic #(
      .WIDTH (WIDTH)
   ) u_logic (
      .a_i    (a_s),
      .b_i    (b_s),
      .c_i    (c_s),
      .code_i (code_s),
      .f_o    (f_d)
   );

   // Asynchronous clear discards any pending result; the first valid value
   // appears on the first edge after release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         f_q <= {WIDTH{OUT_RST_VAL}};
      end else begin
         f_q <= f_d;
      end
   end

   assign o_f = f_q;

endmodule : three_input_gate

// File: tb/tb_three_input_gate.sv
// -----------------------------------------------------------------------------
// tb_three_input_gate
// Bench for three_input_gate: a 1-lane instance driven by a 5-bit sweep
// (a=d[0], b=d[1], c=d[2], i_code=d[4:3]) and a 4-lane instance driven with
// random lanes, both checked against a lane-counting reference model.
// -----------------------------------------------------------------------------
module tb_three_input_gate;

`ifdef THREE_INPUT_GATE_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst_n;
   always #5 i_clk = ~i_clk;

   // ---------------- DUT signals ----------------
   logic       a, b, c;
   logic [1:0] i_code;
   logic       o_f;

   logic [3:0] a4, b4, c4;
   logic [1:0] code4;
   logic [3:0] o_f4;

   three_input_gate dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .a       (a),
      .b       (b),
      .c       (c),
      .i_code  (i_code),
      .o_f     (o_f)
   );

   three_input_gate #(
      .WIDTH (4)
   ) dut4 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .a       (a4),
      .b       (b4),
      .c       (c4),
      .i_code  (code4),
      .o_f     (o_f4)
   );

   // ---------------- scoreboard ----------------
   logic [3:0] exp_q[$];
   logic [3:0] exp4_q[$];
   int         d_q[$];
   int         last_d;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;

   // Reference: count the ones in each lane and apply the gate's rule to the
   // count (all three set, any set, odd count, not all three set).
   function automatic logic [3:0] model(input logic [3:0] av, input logic [3:0] bv,
                                        input logic [3:0] cv, input logic [1:0] k,
                                        input int w);
      logic [3:0] r;
      int ones;
      r = '0;
      for (int l = 0; l < w; l++) begin
         ones = int'(av[l]) + int'(bv[l]) + int'(cv[l]);
         case (k)
            2'd0:    r[l] = (ones == 3);
            2'd1:    r[l] = (ones != 0);
            2'd2:    r[l] = (ones % 2 == 1);
            default: r[l] = (ones != 3);
         endcase
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Empty the pipelines after a reset. With the input stage present the
   // first edge after release yields the reset-decoded 0, so that is queued.
   task automatic flush();
      exp_q.delete();
      exp4_q.delete();
      d_q.delete();
      for (int i = 0; i < LAT - 1; i++) begin
         exp_q.push_back(4'h0);
         exp4_q.push_back(4'h0);
         d_q.push_back(-1);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input int d, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] cv, input logic [1:0] k4);
      logic [4:0] dv;
      dv = d[4:0];
      @(negedge i_clk);
      a      = dv[0];
      b      = dv[1];
      c      = dv[2];
      i_code = dv[4:3];
      a4     = av;
      b4     = bv;
      c4     = cv;
      code4  = k4;
      exp_q.push_back(model({3'b0, dv[0]}, {3'b0, dv[1]}, {3'b0, dv[2]}, dv[4:3], 1));
      exp4_q.push_back(model(av, bv, cv, k4, 4));
      d_q.push_back(d);
      @(posedge i_clk);
      #1;
      check("lane1_f", {3'b0, o_f}, exp_q.pop_front());
      check("lane4_f", o_f4, exp4_q.pop_front());
      last_d = d_q.pop_front();
   endtask

   // Fixed truth-table points, compared when the result for that d is on o_f.
   task automatic spot_check();
      case (last_d)
         7:       check("spot_and_d7",   {3'b0, o_f}, 4'h1);
         8:       check("spot_or_d8",    {3'b0, o_f}, 4'h0);
         19:      check("spot_xor_d19",  {3'b0, o_f}, 4'h0);
         31:      check("spot_nand_d31", {3'b0, o_f}, 4'h0);
         0:       check("spot_and_d0",   {3'b0, o_f}, 4'h0);
         1:       check("spot_and_d1",   {3'b0, o_f}, 4'h0);
         12:      check("spot_or_d12",   {3'b0, o_f}, 4'h1);
         default: ;
      endcase
   endtask

   function automatic logic [3:0] rnd4();
      return 4'($urandom_range(0, 15));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      i_rst_n = 1'b1;
      a = 1'b1; b = 1'b1; c = 1'b1; i_code = 2'b11;
      a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; code4 = 2'b01;

      // Reset asserted between clock edges: output must clear at once.
      #2 i_rst_n = 1'b0;
      #1;
      check("rst_async",  {3'b0, o_f}, 4'h0);
      check("rst_async4", o_f4, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk);
         #1;
         check("rst_hold",  {3'b0, o_f}, 4'h0);
         check("rst_hold4", o_f4, 4'h0);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      flush();

      // Exhaustive sweep, continuing across the 31 -> 0 -> 1 wrap.
      for (int i = 0; i < 34; i++) begin
         step(i % 32, rnd4(), rnd4(), rnd4(), 2'($urandom_range(0, 3)));
         spot_check();
      end

      // Random operands and opcodes.
      for (int i = 0; i < 40; i++) begin
         step(int'($urandom_range(0, 31)), rnd4(), rnd4(), rnd4(), 2'($urandom_range(0, 3)));
         spot_check();
      end

      // Mid-run reset while d=12 (OR with c=1) is on the output.
      for (int i = 0; i < LAT; i++) step(12, 4'h0, 4'h0, 4'h1, 2'b01);
      check("pre_rst_or_d12",  {3'b0, o_f}, 4'h1);
      check("pre_rst_or4",     o_f4, 4'h1);
      #2 i_rst_n = 1'b0;
      #1;
      check("mid_rst_async",  {3'b0, o_f}, 4'h0);
      check("mid_rst_async4", o_f4, 4'h0);
      @(posedge i_clk);
      #1;
      check("mid_rst_hold", {3'b0, o_f}, 4'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      flush();
      for (int i = 0; i < LAT; i++) begin
         step(12, rnd4(), rnd4(), rnd4(), 2'($urandom_range(0, 3)));
         spot_check();
      end
      check("post_rst_d12", {3'b0, o_f}, 4'h1);

      // Four-lane directed points.
      for (int i = 0; i < LAT; i++) step(int'($urandom_range(0, 31)), 4'b1010, 4'b1100, 4'b1111, 2'b10);
      check("w4_xor", o_f4, 4'b1001);
      for (int i = 0; i < LAT; i++) step(int'($urandom_range(0, 31)), 4'b1010, 4'b1100, 4'b1111, 2'b00);
      check("w4_and", o_f4, 4'b1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_three_input_gate
